column_readout_ctrl: RTL and testbench
======================================

Name: column_readout_ctrl

Overview:
- Column-bottom controller for one 16-pixel readout chain.
- Queues incoming L1A triggers and drives the chain's broadcast word (reset, L1A, load).
- After each load, waits for hit counts to settle, then pops every hit word out of the chain with the read strobe.
- Frames each event (header + hit words) onto a valid/ready stream towards the global readout.

Parameters:
L1ADDRWIDTH, 7, width of BC counter / L1A address field
BCSTWIDTH, 27, width of broadcast word to chain
SETTLE_CYCLES, 20, cycles between load pulse and sampling colHits (min 1)
QDEPTH_LOG2, 2, log2 of pending-L1A queue depth (default 4 entries)

Ports:
clk  input  1  40 MHz readout clock
rstn  input  1  asynchronous, active-low reset
l1a  input  1  trigger pulse, one cycle per trigger
softReset  input  1  request chain reset/flush, one-cycle pulse
colHits  input  5  hits remaining at chain bottom, 0..16
colData  input  46  chain bottom data word, valid when colHits!=0
colRead  output  1  one-cycle pop strobe to chain
colBCST  output  BCSTWIDTH  broadcast word to chain
outData  output  46  event stream data
outIsHeader  output  1  current word is header
outLast  output  1  last word of event
outValid  output  1  stream valid
outReady  input  1  stream ready
l1aOverflow  output  1  sticky: trigger dropped because queue full

Behaviour:
- Reset (rstn low, async):
  - all outputs 0; colBCST=0.
  - bcCount=0, queue empty, FSM=IDLE, pending softReset cleared.
- bcCount:
  - L1ADDRWIDTH-bit free-running counter, +1 every clk.
  - wraps 2^L1ADDRWIDTH-1 -> 0.
- L1A capture:
  - on l1a=1 the current bcCount is pushed into the queue.
  - queue full -> trigger dropped, l1aOverflow set (sticky).
  - push and pop in the same cycle while full is legal and does not overflow.
- colBCST fields; remaining bits 0; pulses last exactly one cycle:
  - bit0 reset.
  - bit1 L1A.
  - bit2 load.
  - bits[3+L1ADDRWIDTH-1:3] L1A address; holds last issued address between pulses.
- FSM:
  - IDLE:
    - pending softReset -> RST.
    - else queue non-empty -> pop head, LOAD.
  - RST:
    - bit0 high for 1 cycle; queue flushed; l1aOverflow cleared.
    - -> IDLE.
  - LOAD:
    - bit1 and bit2 high for 1 cycle; address field = popped address.
    - settle counter := SETTLE_CYCLES.
    - -> SETTLE.
  - SETTLE:
    - decrement settle counter; at 0 latch hitCnt=colHits.
    - -> HDR.
  - HDR:
    - outValid=1, outIsHeader=1.
    - outData: [L1ADDRWIDTH-1:0]=address, [12:8]=hitCnt, rest 0.
    - outLast=(hitCnt==0); trailer option below changes this.
    - on outReady: hitCnt==0 -> IDLE (or TRL), else -> DATA.
  - DATA:
    - outValid=1, outData=colData, outIsHeader=0.
    - outLast=1 when this is the hitCnt-th word.
    - on outReady: colRead=1 the same cycle; word counter +1; -> GAP.
  - GAP:
    - one idle cycle so the chain can update colData/colHits.
    - words sent == hitCnt -> IDLE (or TRL), else -> DATA.
- Stream rules:
  - outData/outIsHeader/outLast are stable while outValid && !outReady.
  - outValid never deasserts without a handshake.
- Throughput:
  - 2 cycles per hit word when outReady=1.
  - l1a-to-header latency = 2+SETTLE_CYCLES cycles from an empty queue.
- softReset:
  - latched as pending; served only in IDLE.
  - an event in progress always completes.
  - a softReset arriving together with l1a: the l1a is queued, then flushed by RST.
- colHits==0 sampled in DATA (chain underflow): the word is still sent.
- Hit count above 16: hitCnt is taken as-is (5 bits); the chain guarantees ≤16.

Optional Feature:
EVT_TRAILER_EN
- Defined:
  - after the last data word (or after a zero-hit header), FSM enters TRL.
  - TRL emits one trailer word: outIsHeader=0, outLast=1.
  - outData[45]=1, [12:8]=hitCnt, [13]=underflow flag (colHits==0 seen in DATA), rest 0.
  - header and data words then carry outLast=0.
- Not defined:
  - no TRL state; outLast marks the final header/data word as specified above.

Test Plan:
- Single l1a at bcCount=5, chain holds 3 hits, outReady=1 -> colBCST bits1,2 pulse with addr 5; header addr=5 hitCnt=3 after 22 cycles; 3 data words each 2 cycles apart, 3 colRead pulses; outLast on word 3.
- l1a with colHits=0 -> header only, hitCnt=0, outLast=1, no colRead.
- 6 l1a pulses in consecutive cycles while idle -> first popped immediately, 4 queued, 1 dropped; l1aOverflow=1; exactly 5 events emitted.
- outReady held 0 for 10 cycles during DATA -> outValid stays 1, outData stable, no colRead until ready; then exactly one pop.
- softReset mid-event with 2 queued triggers -> current event completes; one-cycle bit0 pulse; queue empty, l1aOverflow cleared, no further events.
- rstn low during DATA -> outputs 0 immediately; after release FSM is IDLE, bcCount restarts at 0.

Source files
------------

// File: rtl/column_readout_ctrl.sv
// column_readout_ctrl
//   Column-bottom controller for one 16-pixel readout chain. Triggers (l1a)
//   are queued with the bunch-crossing count at which they arrived. Each
//   queued trigger is issued to the chain as an L1A+load broadcast. The
//   controller then waits SETTLE_CYCLES for the hit count to settle and
//   streams the event out as a header followed by one word per hit.
//
//   Optional build macro: EVT_TRAILER_EN
//     Defined   - every event ends with a trailer word carrying the hit count
//                 and an underflow flag; header/data words never set outLast.
//     Undefined - outLast marks the final header or data word of the event.
//
// Ports
//   clk, rstn          readout clock, async active-low reset
//   l1a                one-cycle trigger pulse
//   softReset          one-cycle request to reset/flush the chain
//   colHits, colData   chain bottom hit count (0..16) and data word
//   colRead            one-cycle pop strobe to the chain
//   colBCST            broadcast word: [0] reset, [1] L1A, [2] load,
//                      [3 +: L1ADDRWIDTH] L1A address, remaining bits 0
//   outData/outIsHeader/outLast/outValid/outReady  event stream
//   l1aOverflow        sticky, a trigger was dropped on a full queue
module column_readout_ctrl #(
  parameter int L1ADDRWIDTH   = 7,
  parameter int BCSTWIDTH     = 27,
  parameter int SETTLE_CYCLES = 20,
  parameter int QDEPTH_LOG2   = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 l1a,
  input  logic                 softReset,
  input  logic [4:0]           colHits,
  input  logic [45:0]          colData,
  output logic                 colRead,
  output logic [BCSTWIDTH-1:0] colBCST,
  output logic [45:0]          outData,
  output logic                 outIsHeader,
  output logic                 outLast,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 l1aOverflow
);
  localparam int QDEPTH = 1 << QDEPTH_LOG2;
  localparam int SW     = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, RST, LOAD, SETTLE, HDR, DATA, GAP, TRL} state_t;

`ifdef EVT_TRAILER_EN
  localparam state_t DONE_ST = TRL;
`else
  localparam state_t DONE_ST = IDLE;
`endif

  state_t state, nextState;

  logic [L1ADDRWIDTH-1:0]                  bcCount, addrReg;
  logic [QDEPTH-1:0][L1ADDRWIDTH-1:0]      qMem;
  logic [QDEPTH_LOG2:0]                    wrPtr, rdPtr;
  logic                                    qEmpty, qFull, qPush, qPop, flush;
  logic                                    softPending;
  logic [SW-1:0]                           settleCnt;
  logic [4:0]                              hitCnt, wordCnt;
`ifdef EVT_TRAILER_EN
  logic                                    ufFlag;
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign qEmpty = (wrPtr == rdPtr);
  assign qFull  = (wrPtr[QDEPTH_LOG2] != rdPtr[QDEPTH_LOG2]) &&
                  (wrPtr[QDEPTH_LOG2-1:0] == rdPtr[QDEPTH_LOG2-1:0]);
  assign flush  = (state == RST);
  // A pending softReset takes priority over issuing the next trigger.
  assign qPop   = (state == IDLE) && !softPending && !qEmpty;
  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign qPush  = l1a && !flush && (!qFull || qPop);

  // Trigger queue, BC counter, pending softReset, overflow flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcCount     <= '0;
      qMem        <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      addrReg     <= '0;
      softPending <= 1'b0;
      l1aOverflow <= 1'b0;
    end else begin
      bcCount     <= bcCount + 1'b1;
      softPending <= softReset | (softPending & (state != RST));
      if (flush) begin
        wrPtr       <= '0;
        rdPtr       <= '0;
        l1aOverflow <= 1'b0;
      end else begin
        if (qPush) begin
          qMem[wrPtr[QDEPTH_LOG2-1:0]] <= bcCount;
          wrPtr                        <= wrPtr + 1'b1;
        end
        if (qPop) rdPtr <= rdPtr + 1'b1;
        if (l1a && qFull && !qPop) l1aOverflow <= 1'b1;
      end
      if (qPop) addrReg <= qMem[rdPtr[QDEPTH_LOG2-1:0]];
    end
  end

  // Event datapath: settle timer, latched hit count, words sent
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      settleCnt <= '0;
      hitCnt    <= '0;
      wordCnt   <= '0;
`ifdef EVT_TRAILER_EN
      ufFlag    <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          settleCnt <= SW'(SETTLE_CYCLES);
          wordCnt   <= '0;
`ifdef EVT_TRAILER_EN
          ufFlag    <= 1'b0;
`endif
        end
        SETTLE: begin
          settleCnt <= settleCnt - 1'b1;
          // Counter reaching zero on this edge: sample the settled count.
          if (settleCnt <= SW'(1)) hitCnt <= colHits;
        end
        DATA: begin
          if (outReady) wordCnt <= wordCnt + 5'd1;
`ifdef EVT_TRAILER_EN
          if (colHits == 5'd0) ufFlag <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nextState;
  end

  // FSM next state
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (softPending) nextState = RST;
               else if (!qEmpty) nextState = LOAD;
      RST:     nextState = IDLE;
      LOAD:    nextState = SETTLE;
      SETTLE:  if (settleCnt <= SW'(1)) nextState = HDR;
      HDR:     if (outReady) nextState = (hitCnt == 5'd0) ? DONE_ST : DATA;
      DATA:    if (outReady) nextState = GAP;
      GAP:     nextState = (wordCnt == hitCnt) ? DONE_ST : DATA;
      TRL:     if (outReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    colBCST                    = '0;
    colBCST[3 +: L1ADDRWIDTH]  = addrReg;
    colBCST[0]                 = (state == RST);
    colBCST[1]                 = (state == LOAD);
    colBCST[2]                 = (state == LOAD);
    outValid                   = 1'b0;
    outIsHeader                = 1'b0;
    outLast                    = 1'b0;
    outData                    = '0;
    colRead                    = 1'b0;
    case (state)
      HDR: begin
        outValid                   = 1'b1;
        outIsHeader                = 1'b1;
        outData[L1ADDRWIDTH-1:0]   = addrReg;
        outData[12:8]              = hitCnt;
`ifndef EVT_TRAILER_EN
        outLast                    = (hitCnt == 5'd0);
`endif
      end
      DATA: begin
        outValid = 1'b1;
        outData  = colData;
`ifndef EVT_TRAILER_EN
        outLast  = ((wordCnt + 5'd1) == hitCnt);
`endif
        colRead  = outReady;
      end
`ifdef EVT_TRAILER_EN
      TRL: begin
        outValid      = 1'b1;
        outLast       = 1'b1;
        outData[45]   = 1'b1;
        outData[13]   = ufFlag;
        outData[12:8] = hitCnt;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_column_readout_ctrl.sv
// Bench for column_readout_ctrl: a transaction-level model (trigger queue,
// chain contents, expected event word stream) checked every cycle, plus
// directed scenarios pinned with hand-computed values.
module tb_column_readout_ctrl;
  localparam int L  = 7;
  localparam int BW = 27;
  localparam int S  = 20;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          rstn, l1a, softReset, outReady;
  logic [4:0]    colHits;
  logic [45:0]   colData;
  logic          colRead, outIsHeader, outLast, outValid, l1aOverflow;
  logic [BW-1:0] colBCST;
  logic [45:0]   outData;

  always #12 clk = ~clk;

  column_readout_ctrl #(.L1ADDRWIDTH(L), .BCSTWIDTH(BW), .SETTLE_CYCLES(S),
                        .QDEPTH_LOG2(2)) dut (
    .clk(clk), .rstn(rstn), .l1a(l1a), .softReset(softReset),
    .colHits(colHits), .colData(colData), .colRead(colRead),
    .colBCST(colBCST), .outData(outData), .outIsHeader(outIsHeader),
    .outLast(outLast), .outValid(outValid), .outReady(outReady),
    .l1aOverflow(l1aOverflow));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Chain model: a list of hit words loaded on each load pulse, popped by
  // colRead. An underflowing chain reports 0 hits after its first pop.
  logic [45:0] chainMem [0:31];
  int          chainN = 0, chainIdx = 0;
  bit          chainUf = 0;

  always_comb begin
    colHits = 5'd0;
    colData = 46'd0;
    if (chainIdx < chainN) begin
      colData = chainMem[chainIdx];
      if (!(chainUf && chainIdx >= 1)) colHits = 5'(chainN - chainIdx);
    end
  end

  typedef struct {
    logic [45:0] d;
    logic        hdr;
    logic        last;
  } exp_t;

  // Model state
  int unsigned bcModel = 0;
  logic [L-1:0] trigQ[$];
  exp_t        expQ[$];
  bit          ovfModel = 0, pendModel = 0, prevL1a = 0, prevRst = 0;
  bit          readPending = 0, prevHdrValid = 0;
  logic [L-1:0] prevBc = '0;
  int          cyc = 0, l1aCyc = 0, hdrCyc = 0, nReads = 0, nHdrHs = 0, nRst = 0;
  int          lastReadCyc = 0, prevReadCyc = 0;
  logic [45:0] lastHdrData = '0;
  logic        lastHdrLast = 1'b0;
  logic [L-1:0] lastLoadAddr = '0;
  int          forceHits = -1;
  bit          forceUf = 0;

  always @(negedge clk) begin : monitor
    int n;
    bit uf;
    exp_t e;
    logic [L-1:0] a;
    if (!rstn) begin
      bcModel = 0; trigQ.delete(); expQ.delete();
      ovfModel = 0; pendModel = 0; prevL1a = 0; prevRst = 0;
      readPending = 0; prevHdrValid = 0;
      chainN = 0; chainIdx = 0; chainUf = 0;
    end else begin
      cyc++;
      if (readPending) begin chainIdx++; readPending = 0; end
      chk("bcst_hi_zero", colBCST[BW-1:3+L], 0);
      // Load pulse: the trigger was popped on the previous edge.
      if (colBCST[2]) begin
        chk("load_pair", colBCST[1], 1);
        chk("load_queue_nonempty", trigQ.size() != 0, 1);
        if (trigQ.size() != 0) a = trigQ.pop_front();
        else a = colBCST[3 +: L];
        chk("load_addr", colBCST[3 +: L], a);
        lastLoadAddr = colBCST[3 +: L];
        n  = (forceHits >= 0) ? forceHits : int'($urandom_range(16, 0));
        uf = (forceHits >= 0) ? forceUf : ($urandom_range(7, 0) == 0);
        for (int i = 0; i < n; i++) chainMem[i] = 46'({$urandom(), $urandom()});
        chainN = n; chainIdx = 0; chainUf = uf;
        e.d = '0; e.d[L-1:0] = a; e.d[12:8] = 5'(n); e.hdr = 1'b1;
`ifdef EVT_TRAILER_EN
        e.last = 1'b0;
`else
        e.last = (n == 0);
`endif
        expQ.push_back(e);
        for (int i = 0; i < n; i++) begin
          e.d = chainMem[i]; e.hdr = 1'b0;
`ifdef EVT_TRAILER_EN
          e.last = 1'b0;
`else
          e.last = (i == n - 1);
`endif
          expQ.push_back(e);
        end
`ifdef EVT_TRAILER_EN
        e.d = '0; e.d[45] = 1'b1; e.d[13] = uf && (n >= 2); e.d[12:8] = 5'(n);
        e.hdr = 1'b0; e.last = 1'b1;
        expQ.push_back(e);
`endif
      end else begin
        chk("l1a_without_load", colBCST[1], 0);
      end
      // Trigger from the previous cycle lands after any pop on the same edge.
      if (prevL1a && !prevRst) begin
        if (trigQ.size() < QD) trigQ.push_back(prevBc);
        else ovfModel = 1;
      end
      chk("overflow", l1aOverflow, ovfModel);
      if (colBCST[0]) begin
        chk("rst_only_when_requested", pendModel, 1);
        pendModel = 0; trigQ.delete(); ovfModel = 0; nRst++;
      end
      if (softReset) pendModel = 1;
      if (l1a) l1aCyc = cyc;
      prevL1a = l1a; prevBc = L'(bcModel); prevRst = colBCST[0];
      bcModel = (bcModel + 1) % (1 << L);
      // Stream
      if (outValid && outIsHeader && !prevHdrValid) begin
        hdrCyc = cyc; lastHdrData = outData; lastHdrLast = outLast;
      end
      prevHdrValid = outValid && outIsHeader;
      if (outValid) begin
        chk("stream_expected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          chk("out_data", outData, expQ[0].d);
          chk("out_is_header", outIsHeader, expQ[0].hdr);
          chk("out_last", outLast, expQ[0].last);
          if (outReady) begin
            if (outIsHeader) nHdrHs++;
            void'(expQ.pop_front());
          end
        end
      end
      if (colRead) begin
        chk("read_on_data_handshake", outValid && outReady && !outIsHeader, 1);
        nReads++; readPending = 1;
        prevReadCyc = lastReadCyc; lastReadCyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Wait for model and DUT to go quiet; an expired bound is a failure.
  task automatic drain(input string name, input int budget);
    int n = 0;
    repeat (2) step();
    while (!(trigQ.size() == 0 && expQ.size() == 0 && pendModel == 0 && !outValid)
           && n < budget) begin
      step(); n++;
    end
    chk(name, n < budget, 1);
    repeat (4) step();
  endtask

  task automatic waitHeader(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(outValid && outIsHeader) && n < 200);
    chk(name, outValid && outIsHeader, 1);
  endtask

  initial begin : watchdog
    #(25 * 60000);
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    int h0, r0, s0;
    rstn = 1'b0; l1a = 1'b0; softReset = 1'b0; outReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_colBCST", colBCST, 0);
    chk("rst_outValid", outValid, 0);
    chk("rst_colRead", colRead, 0);
    chk("rst_outData", outData, 0);
    chk("rst_overflow", l1aOverflow, 0);
    rstn = 1'b1;                      // this cycle carries bcCount 0

    // 1: single trigger at bcCount 5, 3 hits
    outReady = 1'b1; forceHits = 3; forceUf = 0;
    repeat (5) step();
    l1a = 1'b1; r0 = nReads;
    step(); l1a = 1'b0;
    drain("t1_drain", 300);
    chk("t1_load_addr", lastLoadAddr, 5);
    chk("t1_hdr", lastHdrData, 46'h305);
    // l1a is sampled on the edge ending its cycle; the header appears
    // 2+SETTLE edges later, i.e. SETTLE+3 cycle indices on.
    chk("t1_hdr_latency", hdrCyc - l1aCyc, S + 3);
    chk("t1_reads", nReads - r0, 3);
    chk("t1_word_spacing", lastReadCyc - prevReadCyc, 2);

    // 2: zero-hit event
    forceHits = 0; r0 = nReads;
    l1a = 1'b1; step(); l1a = 1'b0;
    drain("t2_drain", 300);
    chk("t2_hdr_hits", lastHdrData[12:8], 0);
`ifdef EVT_TRAILER_EN
    chk("t2_hdr_last", lastHdrLast, 0);
`else
    chk("t2_hdr_last", lastHdrLast, 1);
`endif
    chk("t2_reads", nReads - r0, 0);

    // 3: six back-to-back triggers, one dropped
    forceHits = -1; h0 = nHdrHs;
    l1a = 1'b1; repeat (6) step(); l1a = 1'b0;
    chk("t3_overflow", l1aOverflow, 1);
    drain("t3_drain", 1500);
    chk("t3_events", nHdrHs - h0, 5);

    // 4: stall the stream on the first data word
    forceHits = 3; forceUf = 0; r0 = nReads;
    l1a = 1'b1; step(); l1a = 1'b0;
    waitHeader("t4_hdr_seen");
    @(posedge clk); #1; outReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_stall_valid", outValid, 1);
      chk("t4_stall_data", outData, chainMem[0]);
      chk("t4_stall_noread", colRead, 0);
    end
    @(posedge clk); #1; outReady = 1'b1;
    @(negedge clk); chk("t4_pop", colRead, 1);
    @(negedge clk); chk("t4_single_pop", colRead, 0);
    drain("t4_drain", 300);
    chk("t4_reads", nReads - r0, 3);

    // 5: softReset mid-event with two triggers queued behind it
    forceHits = 4; h0 = nHdrHs; r0 = nReads; s0 = nRst;
    l1a = 1'b1; repeat (3) step(); l1a = 1'b0;
    waitHeader("t5_hdr_seen");
    @(posedge clk); #1; softReset = 1'b1;
    step(); softReset = 1'b0;
    drain("t5_drain", 300);
    repeat (60) step();
    chk("t5_events", nHdrHs - h0, 1);
    chk("t5_reads", nReads - r0, 4);
    chk("t5_rst_pulses", nRst - s0, 1);
    chk("t5_overflow_cleared", l1aOverflow, 0);

    // 5b: softReset together with a trigger flushes it
    h0 = nHdrHs; s0 = nRst;
    l1a = 1'b1; softReset = 1'b1; step(); l1a = 1'b0; softReset = 1'b0;
    drain("t5b_drain", 100);
    repeat (40) step();
    chk("t5b_events", nHdrHs - h0, 0);
    chk("t5b_rst_pulses", nRst - s0, 1);

    // 6: async reset during DATA
    forceHits = 5;
    l1a = 1'b1; step(); l1a = 1'b0;
    waitHeader("t6_hdr_seen");
    @(negedge clk); #2;
    rstn = 1'b0; #1;
    chk("t6_rst_valid", outValid, 0);
    chk("t6_rst_data", outData, 0);
    chk("t6_rst_bcst", colBCST, 0);
    chk("t6_rst_read", colRead, 0);
    repeat (2) step();
    rstn = 1'b1; l1a = 1'b1;          // bcCount restarts at 0 here
    step(); l1a = 1'b0;
    drain("t6_drain", 300);
    chk("t6_load_addr", lastLoadAddr, 0);
    chk("t6_hdr_addr", lastHdrData[L-1:0], 0);

    // 7: randomized traffic
    forceHits = -1;
    for (int i = 0; i < 4000; i++) begin
      step();
      l1a       = ($urandom_range(39, 0) == 0);
      softReset = ($urandom_range(299, 0) == 0);
      outReady  = ($urandom_range(3, 0) != 0);
    end
    step();
    l1a = 1'b0; softReset = 1'b0; outReady = 1'b1;
    drain("t7_drain", 2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
